tour_cmd_seq: RTL and testbench

Parametrised successor to the tour command translator. It sits between the UART wrapper, the tour solver and cmd_proc. When idle it passes UART commands through to cmd_proc. After the solver finishes, it replays NUM_MOVES one-hot knight moves as leg commands to cmd_proc and picks the BLE response byte for each completed leg. New relative to the previous generation: configurable tour length, a configurable leg order, and a UART abort during a tour.

---
 rtl/tour_pkg.sv | 37 +++
 rtl/knight_move_decode.sv | 28 ++
 rtl/tour_cmd_seq.sv | 116 +++++++++++
 tb/tb_tour_cmd_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and encodings for the tour command sequencer.
// The sequencer and the knight move decoder both import this package.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEG1,
        WAIT1,
        LEG2,
        WAIT2
    } state_t;

    localparam logic [3:0] OPC_MOVE    = 4'b0010;
    localparam logic [3:0] OPC_FANFARE = 4'b0011;
    localparam logic [3:0] OPC_ABORT   = 4'hF;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE_DEF = 8'hA5;
    localparam logic [7:0] RESP_BUSY_DEF = 8'h5A;

    typedef struct packed {
        logic [7:0] heading;
        logic [3:0] squares;
    } leg_t;

    function automatic leg_t makeLeg(input logic [7:0] heading, input logic [3:0] squares);
        leg_t leg;
        leg.heading = heading;
        leg.squares = squares;
        return leg;
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into its vertical and horizontal legs.
// Anything that is not exactly one-hot becomes a pair of 0-square legs.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] i_move,
    output leg_t       o_vertLeg,
    output leg_t       o_horzLeg
);

    // A zero displacement falls into the "otherwise" heading: S and W.
    always_comb begin
        o_vertLeg = makeLeg(HDG_S, 4'd0);
        o_horzLeg = makeLeg(HDG_W, 4'd0);
        case (i_move)
            8'h01: begin o_vertLeg = makeLeg(HDG_N, 4'd2); o_horzLeg = makeLeg(HDG_E, 4'd1); end
            8'h02: begin o_vertLeg = makeLeg(HDG_N, 4'd2); o_horzLeg = makeLeg(HDG_W, 4'd1); end
            8'h04: begin o_vertLeg = makeLeg(HDG_N, 4'd1); o_horzLeg = makeLeg(HDG_W, 4'd2); end
            8'h08: begin o_vertLeg = makeLeg(HDG_S, 4'd1); o_horzLeg = makeLeg(HDG_W, 4'd2); end
            8'h10: begin o_vertLeg = makeLeg(HDG_S, 4'd2); o_horzLeg = makeLeg(HDG_W, 4'd1); end
            8'h20: begin o_vertLeg = makeLeg(HDG_S, 4'd2); o_horzLeg = makeLeg(HDG_E, 4'd1); end
            8'h40: begin o_vertLeg = makeLeg(HDG_S, 4'd1); o_horzLeg = makeLeg(HDG_E, 4'd2); end
            8'h80: begin o_vertLeg = makeLeg(HDG_N, 4'd1); o_horzLeg = makeLeg(HDG_E, 4'd2); end
            default: begin end
        endcase
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Muxes UART commands to cmd_proc when idle and replays a solved knight's
// tour as two-leg commands. A UART abort command ends the tour early.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int         NUM_MOVES  = 24,
    parameter int         IDX_W      = $clog2(NUM_MOVES),
    parameter int         HORZ_FIRST = 0,
    parameter logic [7:0] RESP_DONE  = RESP_DONE_DEF,
    parameter logic [7:0] RESP_BUSY  = RESP_BUSY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_busy
);

    state_t           r_state;
    logic [IDX_W-1:0] r_mvIndx;
    logic             r_tourBusy;

    leg_t w_vertLeg;
    leg_t w_horzLeg;
    leg_t w_firstLeg;
    leg_t w_secondLeg;
    logic w_abort;
    logic w_lastMove;

    knight_move_decode u_decode (
        .i_move    (move),
        .o_vertLeg (w_vertLeg),
        .o_horzLeg (w_horzLeg)
    );

    assign w_firstLeg  = (HORZ_FIRST != 0) ? w_horzLeg : w_vertLeg;
    assign w_secondLeg = (HORZ_FIRST != 0) ? w_vertLeg : w_horzLeg;
    assign w_abort     = cmd_rdy_UART && (cmd_UART[15:12] == OPC_ABORT) && (r_state != IDLE);
    assign w_lastMove  = (r_mvIndx == IDX_W'(NUM_MOVES - 1));

    // Abort outranks any handshake arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mvIndx   <= '0;
            r_tourBusy <= 1'b0;
        end else if (w_abort) begin
            r_state    <= IDLE;
            r_mvIndx   <= '0;
            r_tourBusy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_tour) begin
                    r_state    <= LEG1;
                    r_mvIndx   <= '0;
                    r_tourBusy <= 1'b1;
                end
                LEG1:  if (clr_cmd_rdy) r_state <= WAIT1;
                WAIT1: if (send_resp)   r_state <= LEG2;
                LEG2:  if (clr_cmd_rdy) r_state <= WAIT2;
                WAIT2: if (send_resp) begin
                    if (w_lastMove) begin
                        r_state    <= IDLE;
                        r_tourBusy <= 1'b0;
                    end else begin
                        r_state  <= LEG1;
                        r_mvIndx <= r_mvIndx + IDX_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A UART command landing on the start_tour cycle is hidden from cmd_proc.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART & ~start_tour;
        resp    = RESP_DONE;
        case (r_state)
            LEG1: begin
                cmd     = {OPC_MOVE, w_firstLeg};
                cmd_rdy = 1'b1;
                resp    = RESP_BUSY;
            end
            WAIT1: begin
                cmd     = {OPC_MOVE, w_firstLeg};
                cmd_rdy = 1'b0;
                resp    = RESP_BUSY;
            end
            LEG2: begin
                cmd     = {OPC_FANFARE, w_secondLeg};
                cmd_rdy = 1'b1;
                resp    = RESP_BUSY;
            end
            WAIT2: begin
                cmd     = {OPC_FANFARE, w_secondLeg};
                cmd_rdy = 1'b0;
                resp    = w_lastMove ? RESP_DONE : RESP_BUSY;
            end
            default: begin end
        endcase
    end

    assign mv_indx   = r_mvIndx;
    assign tour_busy = r_tourBusy;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: a vertical-first 2-move instance and a horizontal-first
// 3-move instance share stimulus; a tour is only ever started on the selected one.
module tb_tour_cmd_seq;

    logic        clk;
    logic        rst;
    logic        startTour;
    logic [7:0]  move;
    logic [15:0] cmdUART;
    logic        cmdRdyUART;
    logic        clrCmdRdy;
    logic        sendResp;
    logic        sel;

    logic [0:0]  mvIdxA;
    logic [15:0] cmdA;
    logic        cmdRdyA;
    logic [7:0]  respA;
    logic        busyA;
    logic [1:0]  mvIdxB;
    logic [15:0] cmdB;
    logic        cmdRdyB;
    logic [7:0]  respB;
    logic        busyB;

    logic        startA;
    logic        startB;
    int          obsIdx;
    logic [15:0] obsCmd;
    logic        obsRdy;
    logic [7:0]  obsResp;
    logic        obsBusy;
    logic [7:0]  moveTab [4];

    int checks = 0;
    int errors = 0;

    assign startA = startTour & ~sel;
    assign startB = startTour & sel;

    tour_cmd_seq #(.NUM_MOVES(2), .HORZ_FIRST(0)) dutA (
        .clk(clk), .rst(rst), .start_tour(startA), .move(move), .mv_indx(mvIdxA),
        .cmd_UART(cmdUART), .cmd_rdy_UART(cmdRdyUART), .clr_cmd_rdy(clrCmdRdy),
        .send_resp(sendResp), .cmd(cmdA), .cmd_rdy(cmdRdyA), .resp(respA), .tour_busy(busyA)
    );

    tour_cmd_seq #(.NUM_MOVES(3), .HORZ_FIRST(1)) dutB (
        .clk(clk), .rst(rst), .start_tour(startB), .move(move), .mv_indx(mvIdxB),
        .cmd_UART(cmdUART), .cmd_rdy_UART(cmdRdyUART), .clr_cmd_rdy(clrCmdRdy),
        .send_resp(sendResp), .cmd(cmdB), .cmd_rdy(cmdRdyB), .resp(respB), .tour_busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The solver side: present the move for whatever index the active DUT is on.
    always_comb begin
        obsIdx  = sel ? int'(mvIdxB) : int'(mvIdxA);
        obsCmd  = sel ? cmdB : cmdA;
        obsRdy  = sel ? cmdRdyB : cmdRdyA;
        obsResp = sel ? respB : respA;
        obsBusy = sel ? busyB : busyA;
        move    = moveTab[obsIdx & 3];
    end

    // Reference: knight displacement table turned into a leg command.
    function automatic logic [15:0] expLeg(input logic [7:0] mv, input bit horzFirst, input bit second);
        int dxTab [8];
        int dyTab [8];
        int dx = 0;
        int dy = 0;
        int sq;
        logic [7:0] hdg;
        dxTab = '{1, -1, -2, -2, -1, 1, 2, 2};
        dyTab = '{2, 2, 1, -1, -2, -2, -1, 1};
        if ($countones(mv) == 1) begin
            for (int k = 0; k < 8; k++) begin
                if (mv[k]) begin
                    dx = dxTab[k];
                    dy = dyTab[k];
                end
            end
        end
        if (horzFirst ^ second) begin
            hdg = (dx > 0) ? 8'hBF : 8'h3F;
            sq  = (dx < 0) ? -dx : dx;
        end else begin
            hdg = (dy > 0) ? 8'h00 : 8'h7F;
            sq  = (dy < 0) ? -dy : dy;
        end
        return {(second ? 4'h3 : 4'h2), hdg, 4'(sq)};
    endfunction

    function automatic logic [7:0] randMove();
        int r = $urandom_range(0, 9);
        if (r < 8) return 8'(1 << r);
        if (r == 8) return 8'h00;
        return 8'h81 | 8'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit st, input bit clr, input bit snd, input bit uRdy,
                                 input logic [15:0] uCmd);
        startTour  = st;
        clrCmdRdy  = clr;
        sendResp   = snd;
        cmdRdyUART = uRdy;
        cmdUART    = uCmd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        applyStimulus(0, 0, 0, 0, 16'h0000);
    endtask

    // Full tour of n moves on the selected DUT, with stray handshakes thrown in.
    task automatic playTour(input int n, input bit horz, input bit coincideUart);
        applyStimulus(1, 0, 0, coincideUart, 16'h2003);
        tick();
        idleInputs();
        for (int i = 0; i < n; i++) begin
            checkOutput("idx", obsIdx, i);
            checkOutput("leg1", obsCmd, expLeg(moveTab[i], horz, 0));
            checkOutput("leg1Rdy", obsRdy, 1);
            checkOutput("busy", obsBusy, 1);
            applyStimulus(1, 0, 1, 0, 16'h0000);
            tick();
            idleInputs();
            checkOutput("leg1Hold", obsRdy, 1);
            applyStimulus(0, 1, 0, 0, 16'h0000);
            tick();
            idleInputs();
            checkOutput("wait1Rdy", obsRdy, 0);
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(0, 0, 1, 0, 16'h0000);
            checkOutput("resp1", obsResp, 32'h5A);
            tick();
            idleInputs();
            checkOutput("leg2", obsCmd, expLeg(moveTab[i], horz, 1));
            checkOutput("leg2Rdy", obsRdy, 1);
            applyStimulus(0, 0, 0, 1, 16'h2003);
            checkOutput("uartIgnored", obsCmd, expLeg(moveTab[i], horz, 1));
            applyStimulus(0, 1, 0, 0, 16'h0000);
            tick();
            idleInputs();
            checkOutput("wait2Rdy", obsRdy, 0);
            applyStimulus(0, 0, 1, 0, 16'h0000);
            checkOutput("resp2", obsResp, (i == n - 1) ? 32'hA5 : 32'h5A);
            checkOutput("busyHold", obsBusy, 1);
            tick();
            idleInputs();
        end
        checkOutput("endBusy", obsBusy, 0);
        checkOutput("endResp", obsResp, 32'hA5);
        applyStimulus(0, 0, 0, 1, 16'h1234);
        checkOutput("endPass", obsCmd, 32'h1234);
        checkOutput("endPassRdy", obsRdy, 1);
        idleInputs();
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) moveTab[i] = 8'h01;
        idleInputs();
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 16'h2003);
        checkOutput("rstCmd", cmdA, 32'h2003);
        checkOutput("rstRdy", cmdRdyA, 1);
        checkOutput("rstResp", respA, 32'hA5);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstIdx", mvIdxA, 0);
        checkOutput("rstCmdB", cmdB, 32'h2003);
        checkOutput("rstBusyB", busyB, 0);
        idleInputs();
        tick();

        moveTab[0] = 8'h01;
        moveTab[1] = 8'h10;
        playTour(2, 0, 0);

        sel = 1'b1;
        moveTab[0] = 8'h04;
        moveTab[1] = randMove();
        moveTab[2] = randMove();
        playTour(3, 1, 1);

        for (int t = 0; t < 4; t++) begin
            sel = t[0];
            for (int i = 0; i < 4; i++) moveTab[i] = randMove();
            tick();
            playTour(sel ? 3 : 2, sel, 0);
        end

        // Abort on the second move of dutA while send_resp arrives too.
        sel = 1'b0;
        moveTab[0] = 8'h02;
        moveTab[1] = 8'h40;
        applyStimulus(1, 0, 0, 0, 16'h0000); tick();
        applyStimulus(0, 1, 0, 0, 16'h0000); tick();
        applyStimulus(0, 0, 1, 0, 16'h0000); tick();
        applyStimulus(0, 1, 0, 0, 16'h0000); tick();
        applyStimulus(0, 0, 1, 0, 16'h0000); tick();
        applyStimulus(0, 1, 0, 0, 16'h0000); tick();
        idleInputs();
        checkOutput("preAbortIdx", obsIdx, 1);
        applyStimulus(0, 0, 1, 1, 16'hF000);
        tick();
        applyStimulus(0, 0, 0, 0, 16'h0BAD);
        checkOutput("abortRdy", obsRdy, 0);
        checkOutput("abortIdx", obsIdx, 0);
        checkOutput("abortBusy", obsBusy, 0);
        checkOutput("abortCmd", obsCmd, 32'h0BAD);
        tick();
        checkOutput("abortNoLeg2", obsRdy, 0);
        idleInputs();

        // Reset during LEG2 of the second move on dutB, then a clean restart.
        sel = 1'b1;
        moveTab[0] = 8'h08;
        moveTab[1] = 8'h20;
        moveTab[2] = 8'h80;
        applyStimulus(1, 0, 0, 0, 16'h0000); tick();
        applyStimulus(0, 1, 0, 0, 16'h0000); tick();
        applyStimulus(0, 0, 1, 0, 16'h0000); tick();
        applyStimulus(0, 1, 0, 0, 16'h0000); tick();
        applyStimulus(0, 0, 1, 0, 16'h0000); tick();
        applyStimulus(0, 1, 0, 0, 16'h0000); tick();
        applyStimulus(0, 0, 1, 0, 16'h0000); tick();
        idleInputs();
        checkOutput("preRstLeg2", obsCmd, expLeg(8'h20, 1, 1));
        checkOutput("preRstIdx", obsIdx, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 16'h1234);
        checkOutput("rst2Rdy", obsRdy, 0);
        checkOutput("rst2Idx", obsIdx, 0);
        checkOutput("rst2Busy", obsBusy, 0);
        checkOutput("rst2Resp", obsResp, 32'hA5);
        checkOutput("rst2Cmd", obsCmd, 32'h1234);
        idleInputs();
        playTour(3, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
